// File: rtl/matmul_apb_master.sv
// -----------------------------------------------------------------------------
// matmul_apb_master
//
// Upstream APB3/APB4 master for the matmul accelerator. Each command accepted
// on the valid/ready command channel becomes exactly one APB transfer on the
// accelerator's slave port. The completion comes back on a valid/ready
// response channel as read data plus an error flag. Writes are held back while
// the accelerator reports busy. Reads are never held back, so status can be
// polled during a computation.
//
// Every output comes from a register. Registered values are computed from the
// next FSM state, so each output changes on the same edge as the state it
// belongs to.
//
// Optional feature:
//   MATMUL_APB_TIMEOUT_EN - when defined, a transfer that sees no pready_i for
//   TIMEOUT_CYCLES ACCESS cycles is ended locally. The response then reports
//   rsp_err_o=1 and rsp_rdata_o=0. When the macro is undefined, ACCESS waits
//   for pready_i with no limit.
//
// Ports:
//   clk_i, rst_ni                 clock; synchronous active-low reset
//   cmd_valid_i / cmd_ready_o     command handshake
//   cmd_write_i, cmd_addr_i,      command: direction, address,
//   cmd_wdata_i, cmd_strb_i         write data, byte strobes
//   rsp_valid_o / rsp_ready_i     response handshake
//   rsp_rdata_o, rsp_err_o        response: read data (0 for writes), error
//   psel_o, penable_o, pwrite_o,  APB request
//   paddr_o, pwdata_o, pstrb_o
//   pready_i, pslverr_i, prdata_i APB completion
//   busy_i                        accelerator busy; gates writes only
// -----------------------------------------------------------------------------
module matmul_apb_master #(
  parameter int DATA_WIDTH     = 8,
  parameter int BUS_WIDTH      = 16,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int MAX_DIM       = BUS_WIDTH / DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // command channel
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
  input  logic [MAX_DIM-1:0]    cmd_strb_i,
  // response channel
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
  output logic                  rsp_err_o,
  // APB master port
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [BUS_WIDTH-1:0]  pwdata_o,
  output logic [MAX_DIM-1:0]    pstrb_o,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  input  logic [BUS_WIDTH-1:0]  prdata_i,
  // accelerator status
  input  logic                  busy_i
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BUSY = 3'd1,
    SETUP     = 3'd2,
    ACCESS    = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic                 accept;
  logic                 cmd_ready_d;
  logic                 psel_d;
  logic                 penable_d;
  logic                 rsp_valid_d;
  logic [BUS_WIDTH-1:0] rsp_rdata_d;
  logic                 rsp_err_d;

  // cmd_ready_o is high only in IDLE. It stays low for the first cycle after
  // reset, because it is a registered output that reset clears.
  assign accept = cmd_valid_i & cmd_ready_o;

`ifdef MATMUL_APB_TIMEOUT_EN
  // The count equals the number of ACCESS cycles already spent without
  // pready_i. When it reaches TMO_LAST, the current cycle is the last one
  // allowed.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tmo_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tmo_cnt <= '0;
    end else if (state == SETUP) begin
      tmo_cnt <= '0;
    end else if (state == ACCESS && !pready_i) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end
`else
  // No watchdog in this build. The name is recognised as intentionally unused.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic and next values of the registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    rsp_rdata_d = rsp_rdata_o;
    rsp_err_d   = rsp_err_o;

    case (state)
      IDLE: begin
        if (accept) begin
          // busy_i only holds back writes. Reads go straight to SETUP.
          state_next = (cmd_write_i && busy_i) ? WAIT_BUSY : SETUP;
        end
      end

      WAIT_BUSY: begin
        if (!busy_i) begin
          state_next = SETUP;
        end
      end

      SETUP: begin
        state_next = ACCESS;
      end

      ACCESS: begin
        if (pready_i) begin
          state_next  = RESP;
          rsp_rdata_d = pwrite_o ? '0 : prdata_i;
          rsp_err_d   = pslverr_i;
        end
`ifdef MATMUL_APB_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          state_next  = RESP;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end
`endif
      end

      RESP: begin
        if (rsp_ready_i) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Control outputs are decoded from the next state. This lets them change
    // on the same edge as the state while still coming from registers.
    cmd_ready_d = (state_next == IDLE);
    psel_d      = (state_next == SETUP) || (state_next == ACCESS);
    penable_d   = (state_next == ACCESS);
    rsp_valid_d = (state_next == RESP);
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cmd_ready_o <= 1'b0;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      state       <= state_next;
      cmd_ready_o <= cmd_ready_d;
      psel_o      <= psel_d;
      penable_o   <= penable_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_rdata_o <= rsp_rdata_d;
      rsp_err_o   <= rsp_err_d;
    end
  end

  // The APB payload registers also hold the latched command. They are loaded
  // only on acceptance, so the payload stays stable through SETUP and ACCESS
  // no matter what the command inputs do afterwards. Read commands load zero
  // write data and zero strobes.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pwrite_o <= 1'b0;
      paddr_o  <= '0;
      pwdata_o <= '0;
      pstrb_o  <= '0;
    end else if (accept) begin
      pwrite_o <= cmd_write_i;
      paddr_o  <= cmd_addr_i;
      pwdata_o <= cmd_write_i ? cmd_wdata_i : '0;
      pstrb_o  <= cmd_write_i ? cmd_strb_i : '0;
    end
  end

endmodule

// File: tb/tb_matmul_apb_master.sv
// -----------------------------------------------------------------------------
// tb_matmul_apb_master
//
// Self-checking bench for matmul_apb_master. Each transfer is described by a
// few plain numbers:
//   - how many cycles the write waits on busy,
//   - how many APB wait states the slave inserts,
//   - how many cycles the response consumer stalls.
// From these, the bench works out the expected cycle-by-cycle handshake
// pattern, payload and response values. The bench acts as the APB slave and
// sequences pready_i from that same cycle plan, never from DUT outputs. All
// inputs it does not care about in a given cycle are randomised.
// -----------------------------------------------------------------------------
module tb_matmul_apb_master;

  localparam int DW  = 8;
  localparam int BW  = 16;
  localparam int AW  = 32;
  localparam int MD  = BW / DW;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_write_i;
  logic [AW-1:0] cmd_addr_i;
  logic [BW-1:0] cmd_wdata_i;
  logic [MD-1:0] cmd_strb_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [BW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic          psel_o;
  logic          penable_o;
  logic          pwrite_o;
  logic [AW-1:0] paddr_o;
  logic [BW-1:0] pwdata_o;
  logic [MD-1:0] pstrb_o;
  logic          pready_i;
  logic          pslverr_i;
  logic [BW-1:0] prdata_i;
  logic          busy_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  matmul_apb_master #(
    .DATA_WIDTH     (DW),
    .BUS_WIDTH      (BW),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_write_i (cmd_write_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_wdata_i (cmd_wdata_i),
    .cmd_strb_i  (cmd_strb_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .psel_o      (psel_o),
    .penable_o   (penable_o),
    .pwrite_o    (pwrite_o),
    .paddr_o     (paddr_o),
    .pwdata_o    (pwdata_o),
    .pstrb_o     (pstrb_o),
    .pready_i    (pready_i),
    .pslverr_i   (pslverr_i),
    .prdata_i    (prdata_i),
    .busy_i      (busy_i)
  );

  // Fill the command fields with junk while no command is being presented.
  task automatic scramble_cmd();
    cmd_write_i = 1'($urandom);
    cmd_addr_i  = AW'($urandom);
    cmd_wdata_i = BW'($urandom);
    cmd_strb_i  = MD'($urandom);
  endtask

  // Wait (bounded) until the DUT is ready for a command.
  task automatic wait_ready(input string tag);
    int guard;
    guard = 0;
    while (cmd_ready_o !== 1'b1 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (cmd_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL %s cmd_ready got=%b want=1", tag, cmd_ready_o);
    end
  endtask

  // Run one full transfer and check every cycle of it.
  //   b : write -> number of WAIT_BUSY cycles (0 = not busy at acceptance)
  //       read  -> b>0 keeps busy_i high for the whole transfer
  //   w : APB wait states inserted by the slave
  //   r : cycles the response consumer holds rsp_ready_i low
  task automatic run_txn(input string tag, input logic wr, input logic [AW-1:0] addr,
                         input logic [BW-1:0] wd, input logic [MD-1:0] st,
                         input int b, input int w, input int r,
                         input logic [BW-1:0] rd, input logic er);
    int s, rsp_first, last;
    logic [3:0]       exp_ctl, got_ctl;
    logic [BW-1:0]    exp_wd, exp_rd;
    logic [MD-1:0]    exp_st;
    logic [AW+BW+MD:0] exp_pay, got_pay;
    logic [BW:0]      exp_rsp, got_rsp;

    wait_ready(tag);
    s         = (wr && b > 0) ? b + 1 : 1;
    rsp_first = s + 2 + w;
    last      = rsp_first + r + 1;
    exp_wd    = wr ? wd : '0;
    exp_st    = wr ? st : '0;
    exp_rd    = wr ? '0 : rd;
    exp_pay   = {wr, addr, exp_wd, exp_st};
    exp_rsp   = {exp_rd, er};

    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_addr_i  = addr;
    cmd_wdata_i = wd;
    cmd_strb_i  = st;
    if (wr)         busy_i = (b > 0);
    else if (b > 0) busy_i = 1'b1;
    else            busy_i = 1'($urandom);
    pready_i    = 1'($urandom);
    pslverr_i   = 1'($urandom);
    prdata_i    = BW'($urandom);
    rsp_ready_i = 1'($urandom);

    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      if (n < s)              exp_ctl = 4'b0000;
      else if (n == s)        exp_ctl = 4'b0100;
      else if (n < rsp_first) exp_ctl = 4'b0110;
      else if (n < last)      exp_ctl = 4'b0001;
      else                    exp_ctl = 4'b1000;
      got_ctl = {cmd_ready_o, psel_o, penable_o, rsp_valid_o};
      total++;
      if (got_ctl !== exp_ctl) begin
        bad++;
        $display("FAIL %s ctl cyc=%0d got=%b want=%b (ready,psel,penable,rspv)",
                 tag, n, got_ctl, exp_ctl);
      end
      if (n >= s && n < rsp_first) begin
        got_pay = {pwrite_o, paddr_o, pwdata_o, pstrb_o};
        total++;
        if (got_pay !== exp_pay) begin
          bad++;
          $display("FAIL %s payload cyc=%0d got=%h want=%h", tag, n, got_pay, exp_pay);
        end
      end
      if (n >= rsp_first && n < last) begin
        got_rsp = {rsp_rdata_o, rsp_err_o};
        total++;
        if (got_rsp !== exp_rsp) begin
          bad++;
          $display("FAIL %s rsp cyc=%0d got=%h want=%h (rdata,err)", tag, n, got_rsp, exp_rsp);
        end
      end

      // stimulus for the next edge
      cmd_valid_i = 1'b0;
      scramble_cmd();
      if (wr && b > 0) busy_i = (n < b) ? 1'b1 : ((n == b) ? 1'b0 : 1'($urandom));
      else if (!wr && b > 0) busy_i = 1'b1;
      else busy_i = 1'($urandom);
      if (n == rsp_first - 1) begin
        pready_i  = 1'b1;
        prdata_i  = rd;
        pslverr_i = er;
      end else begin
        pready_i  = (n > s && n < rsp_first - 1) ? 1'b0 : 1'($urandom);
        prdata_i  = BW'($urandom);
        pslverr_i = 1'($urandom);
      end
      if (n < rsp_first)          rsp_ready_i = 1'($urandom);
      else if (n < rsp_first + r) rsp_ready_i = 1'b0;
      else if (n == rsp_first + r) rsp_ready_i = 1'b1;
      else                        rsp_ready_i = 1'b0;
    end
    pready_i    = 1'b0;
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] ctl;
    rst_ni      = 1'b0;
    cmd_valid_i = 1'b0;
    scramble_cmd();
    rsp_ready_i = 1'b0;
    pready_i    = 1'b0;
    pslverr_i   = 1'b0;
    prdata_i    = '0;
    busy_i      = 1'b0;
    repeat (3) @(negedge clk);
    ctl = {cmd_ready_o, psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o};
    total++;
    if (ctl !== 6'b0 || paddr_o !== '0 || pwdata_o !== '0 || pstrb_o !== '0 || rsp_rdata_o !== '0) begin
      bad++;
      $display("FAIL reset_outputs ctl=%b paddr=%h pwdata=%h pstrb=%b rdata=%h want all 0",
               ctl, paddr_o, pwdata_o, pstrb_o, rsp_rdata_o);
    end
    rst_ni = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_release cmd_ready got=%b want=1", cmd_ready_o);
    end
  endtask

  task automatic test_write_basic();
    run_txn("write_basic", 1'b1, 32'h0000_0010, 16'h0102, 2'b11, 0, 0, 0, BW'($urandom), 1'b0);
  endtask

  task automatic test_read_waits();
    run_txn("read_waits", 1'b0, 32'h0000_0024, BW'($urandom), MD'($urandom), 0, 3, 0, 16'hBEEF, 1'b0);
  endtask

  task automatic test_busy_hold();
    run_txn("busy_write", 1'b1, 32'h0000_0040, 16'hA55A, 2'b01, 10, 1, 0, BW'($urandom), 1'b0);
    run_txn("busy_read", 1'b0, 32'h0000_0044, BW'($urandom), MD'($urandom), 1, 0, 0, 16'h1234, 1'b0);
  endtask

  task automatic test_error_backpressure();
    run_txn("err_write_bp", 1'b1, 32'h0000_0050, 16'hC0DE, 2'b10, 0, 1, 5, BW'($urandom), 1'b1);
    run_txn("err_read_bp", 1'b0, 32'h0000_0054, BW'($urandom), MD'($urandom), 0, 0, 5, 16'h0F0F, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      run_txn("b2b", 1'(i), AW'($urandom), BW'($urandom), MD'($urandom), 0, 0, 0, BW'($urandom), 1'b0);
    end
  endtask

  task automatic test_random();
    logic wr;
    for (int i = 0; i < 30; i++) begin
      wr = 1'($urandom);
      run_txn("random", wr, AW'($urandom), BW'($urandom), MD'($urandom),
              wr ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 1)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
              BW'($urandom), 1'($urandom));
    end
  endtask

  // A read whose slave never answers.
  task automatic test_timeout();
    logic [3:0] got_ctl, exp_ctl;
    logic [AW-1:0] addr;
    addr = AW'($urandom);
    wait_ready("timeout");
    cmd_valid_i = 1'b1;
    cmd_write_i = 1'b0;
    cmd_addr_i  = addr;
    busy_i      = 1'b1;
    pready_i    = 1'b0;
    rsp_ready_i = 1'b0;
`ifdef MATMUL_APB_TIMEOUT_EN
    // SETUP at cycle 1, ACCESS for TMO cycles, then a locally generated error.
    for (int n = 1; n <= TMO + 3; n++) begin
      @(negedge clk);
      if (n == 1)            exp_ctl = 4'b0100;
      else if (n <= TMO + 1) exp_ctl = 4'b0110;
      else if (n == TMO + 2) exp_ctl = 4'b0001;
      else                   exp_ctl = 4'b1000;
      got_ctl = {cmd_ready_o, psel_o, penable_o, rsp_valid_o};
      total++;
      if (got_ctl !== exp_ctl) begin
        bad++;
        $display("FAIL timeout ctl cyc=%0d got=%b want=%b", n, got_ctl, exp_ctl);
      end
      if (n == TMO + 2) begin
        total++;
        if ({rsp_rdata_o, rsp_err_o} !== {BW'(0), 1'b1}) begin
          bad++;
          $display("FAIL timeout rsp rdata=%h err=%b want 0/1", rsp_rdata_o, rsp_err_o);
        end
      end
      cmd_valid_i = 1'b0;
      scramble_cmd();
      prdata_i    = BW'($urandom);
      rsp_ready_i = (n == TMO + 2);
    end
    rsp_ready_i = 1'b0;
`else
    // No watchdog: the transfer must sit in ACCESS, then be aborted by reset.
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      exp_ctl = (n == 1) ? 4'b0100 : 4'b0110;
      got_ctl = {cmd_ready_o, psel_o, penable_o, rsp_valid_o};
      total++;
      if (got_ctl !== exp_ctl || paddr_o !== addr) begin
        bad++;
        $display("FAIL hang ctl cyc=%0d got=%b want=%b paddr=%h want=%h", n, got_ctl, exp_ctl, paddr_o, addr);
      end
      cmd_valid_i = 1'b0;
      scramble_cmd();
      prdata_i    = BW'($urandom);
    end
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    busy_i = 1'b0;
    @(negedge clk);
    got_ctl = {cmd_ready_o, psel_o, penable_o, rsp_valid_o};
    total++;
    if (got_ctl !== 4'b1000) begin
      bad++;
      $display("FAIL hang_recover ctl got=%b want=1000", got_ctl);
    end
`endif
  endtask

  task automatic test_reset_in_access();
    logic [3:0] got_ctl;
    wait_ready("rst_access");
    cmd_valid_i = 1'b1;
    cmd_write_i = 1'b1;
    cmd_addr_i  = 32'h0000_0080;
    cmd_wdata_i = 16'h7777;
    cmd_strb_i  = 2'b11;
    busy_i      = 1'b0;
    pready_i    = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    got_ctl = {cmd_ready_o, psel_o, penable_o, rsp_valid_o};
    total++;
    if (got_ctl !== 4'b0110) begin
      bad++;
      $display("FAIL rst_access pre ctl got=%b want=0110", got_ctl);
    end
    rst_ni = 1'b0;
    @(negedge clk);
    got_ctl = {cmd_ready_o, psel_o, penable_o, rsp_valid_o};
    total++;
    if (got_ctl !== 4'b0000 || paddr_o !== '0 || pwrite_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_access during ctl=%b paddr=%h pwrite=%b want 0", got_ctl, paddr_o, pwrite_o);
    end
    rst_ni = 1'b1;
    pready_i = 1'b1;
    @(negedge clk);
    got_ctl = {cmd_ready_o, psel_o, penable_o, rsp_valid_o};
    total++;
    if (got_ctl !== 4'b1000) begin
      bad++;
      $display("FAIL rst_access after ctl got=%b want=1000", got_ctl);
    end
    pready_i    = 1'b0;
    rsp_ready_i = 1'b0;
    run_txn("post_reset", 1'b0, 32'h0000_0084, BW'($urandom), MD'($urandom), 0, 2, 1, 16'h5AA5, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_waits();
    test_busy_hold();
    test_error_backpressure();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_in_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/matmul_apb_master.md
# matmul_apb_master

Upstream APB master for the matmul accelerator. It accepts single-transfer commands over a valid/ready interface and turns each into one APB3/APB4 transaction on the accelerator's slave port. Writes are held off while the accelerator reports busy. Each completed transfer returns read data and an error flag over a valid/ready response channel. It sits between the system bus-side sequencer/testbench driver and the matmul top-level.

## Interface
Parameters:
- DATA_WIDTH, 8, element width; strobe granularity.
- BUS_WIDTH, 16, APB data width.
- ADDR_WIDTH, 32, APB address width.
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles waiting for pready_i (1..255); used only with the timeout macro.
- Local MAX_DIM = BUS_WIDTH/DATA_WIDTH, the strobe width.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted this cycle when cmd_valid_i is also high.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR_WIDTH  target address.
- cmd_wdata_i  in  BUS_WIDTH  write data.
- cmd_strb_i  in  MAX_DIM  byte strobes (writes only).
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  BUS_WIDTH  read data; 0 for writes.
- rsp_err_o  out  1  pslverr_i or timeout.
- psel_o, penable_o, pwrite_o  out  1  APB control.
- paddr_o  out  ADDR_WIDTH, pwdata_o  out  BUS_WIDTH, pstrb_o  out  MAX_DIM  APB payload.
- pready_i, pslverr_i  in  1; prdata_i  in  BUS_WIDTH  APB slave response.
- busy_i  in  1  accelerator busy (matmul busy_o).

## Operation
- FSM states: IDLE, WAIT_BUSY, SETUP, ACCESS, RESP.
- IDLE: cmd_ready_o=1. On cmd_valid_i, the command is latched into internal registers.
  - Write with busy_i=1 → WAIT_BUSY.
  - Otherwise → SETUP.
- WAIT_BUSY: remains until busy_i=0 is sampled, then → SETUP. No timeout applies here.
- SETUP: psel_o=1, penable_o=0, payload driven from the latched command. Always exactly one cycle → ACCESS.
- ACCESS: psel_o=1, penable_o=1, payload held stable. On pready_i=1:
  - capture prdata_i (reads) or 0 (writes) into rsp_rdata_o;
  - capture pslverr_i into rsp_err_o;
  - → RESP.
- RESP: psel_o=0, rsp_valid_o=1, rsp data held until rsp_ready_i=1, then → IDLE.
- Reads are never gated by busy_i; status reads during a computation are allowed.
- pstrb_o is driven from cmd_strb_i for writes and forced to 0 for reads.
- pwdata_o is 0 for reads.
- All outputs are registered.
- Reset (rst_ni=0 at a clock edge) sets all outputs to 0, the FSM to IDLE, and clears the latched command. This applies mid-transaction too: psel_o and penable_o drop on the reset edge, and no response is issued for the aborted command.

## Timing
- Command accepted at edge T: psel_o=1 from T+1 (SETUP), penable_o=1 from T+2 (ACCESS).
- Zero-wait slave (pready_i=1 in the first ACCESS cycle): rsp_valid_o=1 from T+3. Minimum command-to-response latency is 3 cycles.
- Each wait state (pready_i=0 in ACCESS) adds one cycle.
- Back-to-back throughput with rsp_ready_i held high: one transfer per 4 cycles. The RESP→IDLE cycle is not overlapped.
- psel_o falls in the cycle after the pready_i handshake; penable_o falls with it.
- busy_i is sampled only in IDLE (at acceptance) and in WAIT_BUSY. A busy_i rise during SETUP/ACCESS does not abort the transfer.

## Configuration
- MATMUL_APB_TIMEOUT_EN defined:
  - an 8-bit counter clears on entry to ACCESS and increments every ACCESS cycle with pready_i=0;
  - when it reaches TIMEOUT_CYCLES, the FSM → RESP with rsp_err_o=1 and rsp_rdata_o=0;
  - psel_o/penable_o deassert on that cycle.
- Not defined: no counter; ACCESS waits indefinitely for pready_i.

## Test plan
- Write: cmd addr 0x0000_0010, wdata 16'h0102, strb 2'b11; slave pready immediate → psel at T+1, penable at T+2, rsp_valid at T+3 with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: slave returns prdata 16'hBEEF → rsp_valid at T+6 with rsp_rdata=16'hBEEF; paddr_o and pwrite_o=0 stable for the whole access.
- Busy hold: busy_i=1 at write acceptance, released 10 cycles later → psel stays 0 until the cycle after busy_i=0 is sampled. A read issued while busy proceeds immediately.
- Error plus backpressure: pslverr_i=1 with pready_i → rsp_err=1. rsp_ready_i held low for 5 cycles → rsp_valid and data stable, cmd_ready_o=0 throughout.
- Timeout (macro on, TIMEOUT_CYCLES=16): pready_i never asserted → rsp_valid with rsp_err=1, rsp_rdata=0 after 16 ACCESS cycles. With the macro off, the FSM stays in ACCESS.
- Reset in ACCESS: rst_ni=0 for one edge → next cycle psel/penable/rsp_valid=0 and cmd_ready_o=1 after release; a new command completes normally.
